// File: rtl/f1_race_ctrl.sv
// f1_race_ctrl: sequencer for the F1 start-light FSM.
// It arms the light FSM and paces its steps with a divided tick. It then holds
// for a random number of ticks taken from an LFSR and signals lights-out.
// Finally it times the driver's reaction and flags jump starts.
module f1_race_ctrl #(
  parameter int TICK_DIV = 24,
  parameter int LFSR_W   = 7,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             react,
  input  logic             cmd_delay,
  output logic             trigger,
  output logic             seq_tick,
  output logic             lights_out,
  output logic             react_valid,
  output logic [CNT_W-1:0] react_time,
  output logic             jump_start,
  output logic             busy
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Feedback taps for a left-shifting Fibonacci LFSR (bit i set = tap on x^(i+1)).
  // Widths 3..12 are maximal length. Any other width still keeps the MSB tap,
  // so a non-zero state can never collapse to zero.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0044;  // x^7 + x^3 + 1
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0E08;
      default: tap_mask = (32'h1 << (w - 1)) | 32'h1;
    endcase
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & TAPS)};
  endfunction

  // Reaction counter increment that sticks at full scale.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEQ    = 3'd1,
    S_DELAY  = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   delay_q, delay_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;
  logic [CNT_W-1:0]    rtime_q, rtime_d;
  logic                jump_q, jump_d;
  logic                trig_q, trig_d;
  logic                tick_q, tick_d;
  logic                lo_q, lo_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                start_q, react_q;
  logic                start_rise, react_rise, tick;

  assign start_rise = start & ~start_q;
  assign react_rise = react & ~react_q;
  assign tick       = (div_q == DIV_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, counters and registered output pulses.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    delay_d = delay_q;
    rcnt_d  = rcnt_q;
    rtime_d = rtime_q;
    jump_d  = jump_q;
    trig_d  = 1'b0;
    tick_d  = 1'b0;
    lo_d    = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d = S_SEQ;
          trig_d  = 1'b1;
          div_d   = '0;
          jump_d  = 1'b0;
          rtime_d = '0;
        end
      end
      S_SEQ: begin
        if (cmd_delay) begin
          // The step that would have fired here is dropped: the FSM is already waiting.
          state_d = S_DELAY;
          delay_d = lfsr_q;
          div_d   = '0;
        end else begin
          div_d  = tick ? '0 : div_q + DIV_W'(1);
          tick_d = tick;
        end
      end
      S_DELAY: begin
        if (react_rise) begin
          // A press on the final tick still counts as a jump start and suppresses lights-out.
          state_d = S_DONE;
          jump_d  = 1'b1;
        end else begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (tick) begin
            delay_d = delay_q - LFSR_W'(1);
            if (delay_q == LFSR_W'(1)) begin
              state_d = S_TIMING;
              lo_d    = 1'b1;
              rcnt_d  = '0;
            end
          end
        end
      end
      S_TIMING: begin
        if (react_rise || (rcnt_q == CNT_MAX)) begin
          state_d = S_DONE;
          rtime_d = rcnt_q;
          valid_d = 1'b1;
        end else begin
          rcnt_d = sat_inc(rcnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SEQ) || (state_d == S_DELAY) || (state_d == S_TIMING);
  end

  // Counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      delay_q <= '0;
      rcnt_q  <= '0;
      rtime_q <= '0;
      jump_q  <= 1'b0;
      trig_q  <= 1'b0;
      tick_q  <= 1'b0;
      lo_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      delay_q <= delay_d;
      rcnt_q  <= rcnt_d;
      rtime_q <= rtime_d;
      jump_q  <= jump_d;
      trig_q  <= trig_d;
      tick_q  <= tick_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // The LFSR free-runs every cycle, so the hold depends on when the race is started.
  // The button history registers give the one-cycle rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q  <= LFSR_W'(1);
      start_q <= 1'b0;
      react_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_step(lfsr_q);
      start_q <= start;
      react_q <= react;
    end
  end

  assign trigger     = trig_q;
  assign seq_tick    = tick_q;
  assign lights_out  = lo_q;
  assign react_valid = valid_q;
  assign react_time  = rtime_q;
  assign jump_start  = jump_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_f1_race_ctrl.sv
// Bench for f1_race_ctrl with TICK_DIV=4, LFSR_W=7, CNT_W=8.
// The expected hold length comes from the x^7+x^3+1 sequence, counted in
// clocks since reset. Expected timings come from tick arithmetic.
module tb_f1_race_ctrl;
  localparam int TICK_DIV = 4;
  localparam int LFSR_W   = 7;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic react = 1'b0;
  logic cmd_delay = 1'b0;
  logic trigger, seq_tick, lights_out, react_valid, jump_start, busy;
  logic [CNT_W-1:0] react_time;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc;

  f1_race_ctrl #(.TICK_DIV(TICK_DIV), .LFSR_W(LFSR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .react(react), .cmd_delay(cmd_delay),
    .trigger(trigger), .seq_tick(seq_tick), .lights_out(lights_out),
    .react_valid(react_valid), .react_time(react_time),
    .jump_start(jump_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release: equals the number of LFSR shifts so far.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Value of the x^7+x^3+1 sequence n steps after the seed 1.
  function automatic int hold_after(input int unsigned n);
    logic [6:0] v;
    v = 7'd1;
    for (int unsigned k = 0; k < n; k++) v = {v[5:0], v[6] ^ v[2]};
    return int'(v);
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; react = 1'b0; cmd_delay = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Arm a race, stay in the sequence phase, then request the hold.
  // Returns at the first negedge after the hold was captured.
  task automatic arm_and_delay(input int idle_wait, input int seq_wait, output int n);
    start = 1'b0;
    @(negedge clk);
    repeat (idle_wait) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (seq_wait) @(negedge clk);
    cmd_delay = 1'b1;
    n = hold_after(cyc);
    @(negedge clk);
    cmd_delay = 1'b0;
  endtask

  task automatic wait_lights_out(input int limit, output int idx);
    idx = -1;
    for (int i = 0; i <= limit; i++) begin
      if (lights_out === 1'b1) begin
        idx = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst = 1'b1;
    @(negedge clk);
    outs = {trigger, seq_tick, lights_out, react_valid, jump_start, busy, react_time};
    n_checks++;
    if (outs !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    outs = {trigger, seq_tick, lights_out, react_valid, jump_start, busy, react_time};
    n_checks++;
    if (outs !== 14'd0) begin
      n_fail++; $display("FAIL idle_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_arming();
    logic exp_tick;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({trigger, busy} !== 2'b11) begin
      n_fail++; $display("FAIL arm_trigger: trigger,busy=%b expected 11", {trigger, busy});
    end
    for (int j = 1; j <= 16; j++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_tick = ((j % TICK_DIV) == 0);
      n_checks++;
      if (trigger !== 1'b0) begin
        n_fail++; $display("FAIL arm_retrigger: cycle %0d trigger=%b expected 0", j, trigger);
      end
      n_checks++;
      if (seq_tick !== exp_tick) begin
        n_fail++; $display("FAIL seq_tick: cycle %0d got %b expected %b", j, seq_tick, exp_tick);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_hold();
    int n, lo_idx, lo_cnt, st_cnt;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      arm_and_delay($urandom_range(0, 30), $urandom_range(0, 9), n);
      lo_idx = -1; lo_cnt = 0; st_cnt = 0;
      for (int i = 0; i <= 4 * n + 2; i++) begin
        if (seq_tick === 1'b1) st_cnt++;
        if (lights_out === 1'b1) begin
          lo_cnt++;
          if (lo_idx < 0) lo_idx = i;
        end
        @(negedge clk);
      end
      n_checks++;
      if (lo_idx != 4 * n) begin
        n_fail++; $display("FAIL hold_length: lights_out at %0d expected %0d (N=%0d)", lo_idx, 4 * n, n);
      end
      n_checks++;
      if (lo_cnt != 1) begin
        n_fail++; $display("FAIL lights_out_width: %0d cycles expected 1", lo_cnt);
      end
      n_checks++;
      if (st_cnt != 0) begin
        n_fail++; $display("FAIL seq_tick_in_hold: %0d ticks expected 0", st_cnt);
      end
    end
  endtask

  task automatic test_reaction();
    int n, idx, r;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      r = (it == 0) ? 10 : (it == 1) ? 0 : int'($urandom_range(1, 40));
      arm_and_delay($urandom_range(0, 10), $urandom_range(0, 6), n);
      wait_lights_out(4 * n + 8, idx);
      n_checks++;
      if (idx != 4 * n) begin
        n_fail++; $display("FAIL react_hold: lights_out at %0d expected %0d", idx, 4 * n);
      end
      repeat (r) @(negedge clk);
      react = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({react_valid, jump_start, busy} !== 3'b100) begin
        n_fail++; $display("FAIL react_flags: valid,jump,busy=%b expected 100", {react_valid, jump_start, busy});
      end
      n_checks++;
      if (react_time !== CNT_W'(r)) begin
        n_fail++; $display("FAIL react_time: got %0d expected %0d", react_time, r);
      end
      react = 1'b0;
      @(negedge clk);
      n_checks++;
      if (react_valid !== 1'b0 || react_time !== CNT_W'(r)) begin
        n_fail++; $display("FAIL react_hold_value: valid=%b time=%0d expected 0/%0d", react_valid, react_time, r);
      end
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({trigger, busy, jump_start} !== 3'b110 || react_time !== '0) begin
      n_fail++; $display("FAIL rearm_from_done: trig,busy,jump=%b time=%0d expected 110/0",
                         {trigger, busy, jump_start}, react_time);
    end
    start = 1'b0;
  endtask

  task automatic test_jump_start();
    int n, k, bad;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      arm_and_delay($urandom_range(0, 20), $urandom_range(0, 6), n);
      k = (it == 0) ? 4 * n - 1 : int'($urandom_range(0, 4 * n - 1));
      repeat (k) @(negedge clk);
      react = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({jump_start, busy, react_valid, lights_out} !== 4'b1000) begin
        n_fail++; $display("FAIL jump_flags: jump,busy,valid,lo=%b expected 1000 (k=%0d)",
                           {jump_start, busy, react_valid, lights_out}, k);
      end
      bad = 0;
      for (int i = 0; i < 4 * n + 20; i++) begin
        if (lights_out === 1'b1 || react_valid === 1'b1) bad++;
        @(negedge clk);
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL jump_no_lights: %0d pulses expected 0", bad);
      end
      react = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if ({jump_start, trigger} !== 2'b01) begin
        n_fail++; $display("FAIL jump_clear: jump,trigger=%b expected 01", {jump_start, trigger});
      end
    end
  endtask

  task automatic test_held_react();
    int n, idx;
    do_reset();
    react = 1'b1;
    arm_and_delay($urandom_range(0, 10), $urandom_range(0, 6), n);
    wait_lights_out(4 * n + 8, idx);
    n_checks++;
    if (idx != 4 * n || jump_start !== 1'b0) begin
      n_fail++; $display("FAIL held_react_hold: lo at %0d jump=%b expected %0d/0", idx, jump_start, 4 * n);
    end
    repeat (5) @(negedge clk);
    react = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (react_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL held_react_ignored: valid=%b busy=%b expected 0/1", react_valid, busy);
    end
    react = 1'b1;
    @(negedge clk);
    n_checks++;
    if (react_valid !== 1'b1 || react_time !== CNT_W'(8)) begin
      n_fail++; $display("FAIL held_react_time: valid=%b time=%0d expected 1/8", react_valid, react_time);
    end
    react = 1'b0;
  endtask

  task automatic test_timeout();
    int n, idx, v_idx, trig_cnt;
    logic [CNT_W-1:0] rt;
    logic busy_late, busy_after;
    do_reset();
    arm_and_delay($urandom_range(0, 10), $urandom_range(0, 6), n);
    wait_lights_out(4 * n + 8, idx);
    n_checks++;
    if (idx != 4 * n) begin
      n_fail++; $display("FAIL timeout_hold: lights_out at %0d expected %0d", idx, 4 * n);
    end
    v_idx = -1; trig_cnt = 0; rt = '0; busy_late = 1'b0; busy_after = 1'b1;
    for (int i = 1; i <= 262; i++) begin
      start = (i < 250) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (trigger === 1'b1) trig_cnt++;
      if (i == 255) busy_late = busy;
      if (i == 257) busy_after = busy;
      if (react_valid === 1'b1 && v_idx < 0) begin
        v_idx = i;
        rt = react_time;
      end
    end
    n_checks++;
    if (v_idx != CNT_MAX + 1 || rt !== CNT_W'(CNT_MAX)) begin
      n_fail++; $display("FAIL timeout_report: valid at %0d time=%0d expected %0d/%0d", v_idx, rt, CNT_MAX + 1, CNT_MAX);
    end
    n_checks++;
    if (trig_cnt != 0) begin
      n_fail++; $display("FAIL busy_start_ignored: %0d triggers expected 0", trig_cnt);
    end
    n_checks++;
    if ({busy_late, busy_after} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_busy: before,after=%b expected 10", {busy_late, busy_after});
    end
  endtask

  task automatic test_reset_mid_delay();
    int n, k, idx;
    logic [13:0] outs;
    do_reset();
    arm_and_delay($urandom_range(0, 20), $urandom_range(0, 6), n);
    k = int'($urandom_range(0, 4 * n - 1));
    repeat (k) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_delay_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    outs = {trigger, seq_tick, lights_out, react_valid, jump_start, busy, react_time};
    n_checks++;
    if (outs !== 14'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    arm_and_delay(2, 3, n);
    wait_lights_out(4 * n + 8, idx);
    n_checks++;
    if (idx != 4 * n) begin
      n_fail++; $display("FAIL lfsr_after_reset: lights_out at %0d expected %0d", idx, 4 * n);
    end
  endtask

  initial begin
    test_reset();
    test_arming();
    test_hold();
    test_reaction();
    test_back_to_back();
    test_jump_start();
    test_held_react();
    test_timeout();
    test_reset_mid_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
